// File: rtl/axi_rd_wr_arb.sv
// Two-master (IFU read-only, LSU read/write) to one-slave AXI4-Lite arbiter.
// Whole transactions are serialised; masters are granted round-robin.
module axi_rd_wr_arb #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    // master 0 (IFU)
    input  logic                  m0_ar_valid,
    output logic                  m0_ar_ready,
    input  logic [ADDR_W-1:0]     m0_ar_addr,
    output logic                  m0_r_valid,
    input  logic                  m0_r_ready,
    output logic [DATA_W-1:0]     m0_r_data,
    output logic [1:0]            m0_r_resp,
    // master 1 (LSU)
    input  logic                  m1_ar_valid,
    output logic                  m1_ar_ready,
    input  logic [ADDR_W-1:0]     m1_ar_addr,
    output logic                  m1_r_valid,
    input  logic                  m1_r_ready,
    output logic [DATA_W-1:0]     m1_r_data,
    output logic [1:0]            m1_r_resp,
    input  logic                  m1_aw_valid,
    output logic                  m1_aw_ready,
    input  logic [ADDR_W-1:0]     m1_aw_addr,
    input  logic                  m1_w_valid,
    output logic                  m1_w_ready,
    input  logic [DATA_W-1:0]     m1_w_data,
    input  logic [DATA_W/8-1:0]   m1_w_strb,
    output logic                  m1_b_valid,
    input  logic                  m1_b_ready,
    output logic [1:0]            m1_b_resp,
    // slave
    output logic                  s_ar_valid,
    input  logic                  s_ar_ready,
    output logic [ADDR_W-1:0]     s_ar_addr,
    input  logic                  s_r_valid,
    output logic                  s_r_ready,
    input  logic [DATA_W-1:0]     s_r_data,
    input  logic [1:0]            s_r_resp,
    output logic                  s_aw_valid,
    input  logic                  s_aw_ready,
    output logic [ADDR_W-1:0]     s_aw_addr,
    output logic                  s_w_valid,
    input  logic                  s_w_ready,
    output logic [DATA_W-1:0]     s_w_data,
    output logic [DATA_W/8-1:0]   s_w_strb,
    input  logic                  s_b_valid,
    output logic                  s_b_ready,
    input  logic [1:0]            s_b_resp
);

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD_A = 3'd1;
    localparam logic [2:0] RD_D = 3'd2;
    localparam logic [2:0] WR_A = 3'd3;
    localparam logic [2:0] WR_B = 3'd4;

    logic [2:0] state_q, state_d;
    logic       gnt_q, gnt_d;
    logic       last_q, last_d;
    logic       aw_done_q, aw_done_d;
    logic       w_done_q, w_done_d;

    logic req0, req1, m1_wr, win, aw_fin, w_fin;

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        last_d    = last_q;
        aw_done_d = aw_done_q;
        w_done_d  = w_done_q;

        req0   = m0_ar_valid;
        m1_wr  = m1_aw_valid & m1_w_valid;
        req1   = m1_ar_valid | m1_wr;
        win    = 1'b0;
        aw_fin = 1'b0;
        w_fin  = 1'b0;

        m0_ar_ready = 1'b0;
        m0_r_valid  = 1'b0;
        m0_r_data   = '0;
        m0_r_resp   = 2'b00;
        m1_ar_ready = 1'b0;
        m1_r_valid  = 1'b0;
        m1_r_data   = '0;
        m1_r_resp   = 2'b00;
        m1_aw_ready = 1'b0;
        m1_w_ready  = 1'b0;
        m1_b_valid  = 1'b0;
        m1_b_resp   = 2'b00;
        s_ar_valid  = 1'b0;
        s_ar_addr   = '0;
        s_r_ready   = 1'b0;
        s_aw_valid  = 1'b0;
        s_aw_addr   = '0;
        s_w_valid   = 1'b0;
        s_w_data    = '0;
        s_w_strb    = '0;
        s_b_ready   = 1'b0;

        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    win     = (req0 & req1) ? ~last_q : req1;
                    gnt_d   = win;
                    last_d  = win;
                    // LSU write beats its own pending read to keep store-before-load order
                    state_d = (win & m1_wr) ? WR_A : RD_A;
                end
            end
            RD_A: begin
                s_ar_valid = gnt_q ? m1_ar_valid : m0_ar_valid;
                s_ar_addr  = gnt_q ? m1_ar_addr : m0_ar_addr;
                if (gnt_q) m1_ar_ready = s_ar_ready;
                else       m0_ar_ready = s_ar_ready;
                if (s_ar_valid & s_ar_ready) state_d = RD_D;
            end
            RD_D: begin
                if (gnt_q) begin
                    m1_r_valid = s_r_valid;
                    m1_r_data  = s_r_data;
                    m1_r_resp  = s_r_resp;
                    s_r_ready  = m1_r_ready;
                end else begin
                    m0_r_valid = s_r_valid;
                    m0_r_data  = s_r_data;
                    m0_r_resp  = s_r_resp;
                    s_r_ready  = m0_r_ready;
                end
                if (s_r_valid & s_r_ready) state_d = IDLE;
            end
            WR_A: begin
                s_aw_valid  = m1_aw_valid & ~aw_done_q;
                s_aw_addr   = m1_aw_addr;
                m1_aw_ready = s_aw_ready & ~aw_done_q;
                s_w_valid   = m1_w_valid & ~w_done_q;
                s_w_data    = m1_w_data;
                s_w_strb    = m1_w_strb;
                m1_w_ready  = s_w_ready & ~w_done_q;
                aw_fin      = aw_done_q | (s_aw_valid & s_aw_ready);
                w_fin       = w_done_q | (s_w_valid & s_w_ready);
                if (aw_fin & w_fin) begin
                    state_d   = WR_B;
                    aw_done_d = 1'b0;
                    w_done_d  = 1'b0;
                end else begin
                    aw_done_d = aw_fin;
                    w_done_d  = w_fin;
                end
            end
            WR_B: begin
                m1_b_valid = s_b_valid;
                m1_b_resp  = s_b_resp;
                s_b_ready  = m1_b_ready;
                if (s_b_valid & m1_b_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            gnt_q     <= 1'b0;
            last_q    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            last_q    <= last_d;
            aw_done_q <= aw_done_d;
            w_done_q  <= w_done_d;
        end
    end

endmodule
